// File: rtl/manta_bus_arbiter.sv
// manta_bus_arbiter: round-robin arbiter sharing one fixed-latency LUT-RAM core bus between two masters.
// Define MANTA_ARB_STATS_EN to add per-port saturating grant counters and a sticky overrun flag.
module manta_bus_arbiter #(
    parameter int ADDR_WIDTH   = 16,
    parameter int DATA_WIDTH   = 16,
    parameter int CORE_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    input  logic                  a_rw,
    input  logic                  a_valid,
    output logic                  a_ready,
    output logic [DATA_WIDTH-1:0] a_rdata,
    output logic                  a_rvalid,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_wdata,
    input  logic                  b_rw,
    input  logic                  b_valid,
    output logic                  b_ready,
    output logic [DATA_WIDTH-1:0] b_rdata,
    output logic                  b_rvalid,
    output logic [ADDR_WIDTH-1:0] core_addr,
    output logic [DATA_WIDTH-1:0] core_wdata,
    output logic                  core_rw,
    output logic                  core_valid,
    input  logic [DATA_WIDTH-1:0] core_rdata,
    input  logic                  core_rvalid
`ifdef MANTA_ARB_STATS_EN
    ,
    output logic [15:0]           a_grants,
    output logic [15:0]           b_grants,
    output logic                  overrun
`endif
);

    typedef enum logic {PORT_A = 1'b0, PORT_B = 1'b1} port_t;

    port_t                   last_grant, last_grant_next;
    logic                    a_full, b_full;
    logic [ADDR_WIDTH-1:0]   a_addr_q, b_addr_q;
    logic [DATA_WIDTH-1:0]   a_wdata_q, b_wdata_q;
    logic                    a_rw_q, b_rw_q;
    logic                    grant_a, grant_b;
    logic                    a_accept, b_accept;
    logic                    core_port;
    logic [CORE_LATENCY-1:0] tag_read, tag_port;
    logic [CORE_LATENCY:0]   read_shift, port_shift;
    logic                    resp;

    always_ff @(posedge clk) begin
        if (!rstn)
            last_grant <= PORT_B;
        else
            last_grant <= last_grant_next;
    end

    always_comb begin
        last_grant_next = grant_a ? PORT_A : grant_b ? PORT_B : last_grant;
    end

    always_comb begin
        grant_a  = a_full & (~b_full | (last_grant == PORT_B));
        grant_b  = b_full & (~a_full | (last_grant == PORT_A));
        a_ready  = ~a_full | grant_a;
        b_ready  = ~b_full | grant_b;
        a_accept = a_valid & a_ready;
        b_accept = b_valid & b_ready;
    end

    // A drain and a refill in the same cycle keep the slot full for streaming.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            a_full    <= 1'b0;
            a_addr_q  <= '0;
            a_wdata_q <= '0;
            a_rw_q    <= 1'b0;
            b_full    <= 1'b0;
            b_addr_q  <= '0;
            b_wdata_q <= '0;
            b_rw_q    <= 1'b0;
        end else begin
            if (a_accept) begin
                a_full    <= 1'b1;
                a_addr_q  <= a_addr;
                a_wdata_q <= a_wdata;
                a_rw_q    <= a_rw;
            end else if (grant_a) begin
                a_full <= 1'b0;
            end
            if (b_accept) begin
                b_full    <= 1'b1;
                b_addr_q  <= b_addr;
                b_wdata_q <= b_wdata;
                b_rw_q    <= b_rw;
            end else if (grant_b) begin
                b_full <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            core_valid <= 1'b0;
            core_addr  <= '0;
            core_wdata <= '0;
            core_rw    <= 1'b0;
            core_port  <= 1'b0;
        end else begin
            core_valid <= grant_a | grant_b;
            if (grant_a | grant_b) begin
                core_addr  <= grant_a ? a_addr_q : b_addr_q;
                core_wdata <= grant_a ? a_wdata_q : b_wdata_q;
                core_rw    <= grant_a ? a_rw_q : b_rw_q;
                core_port  <= grant_b;
            end
        end
    end

    // The tail of the tag pipe lines up with the core response for the same request.
    always_comb begin
        read_shift = {tag_read, core_valid & ~core_rw};
        port_shift = {tag_port, core_port};
        resp       = core_rvalid & tag_read[CORE_LATENCY-1];
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            tag_read <= '0;
            tag_port <= '0;
        end else begin
            tag_read <= read_shift[CORE_LATENCY-1:0];
            tag_port <= port_shift[CORE_LATENCY-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            a_rvalid <= 1'b0;
            b_rvalid <= 1'b0;
            a_rdata  <= '0;
            b_rdata  <= '0;
        end else begin
            a_rvalid <= resp & ~tag_port[CORE_LATENCY-1];
            b_rvalid <= resp & tag_port[CORE_LATENCY-1];
            if (resp & ~tag_port[CORE_LATENCY-1])
                a_rdata <= core_rdata;
            if (resp & tag_port[CORE_LATENCY-1])
                b_rdata <= core_rdata;
        end
    end

`ifdef MANTA_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (!rstn) begin
            a_grants <= '0;
            b_grants <= '0;
            overrun  <= 1'b0;
        end else begin
            if (grant_a && a_grants != 16'hFFFF)
                a_grants <= a_grants + 16'd1;
            if (grant_b && b_grants != 16'hFFFF)
                b_grants <= b_grants + 16'd1;
            overrun <= overrun | (a_valid & ~a_ready) | (b_valid & ~b_ready);
        end
    end
`endif

endmodule
